// File: rtl/bool3_truth_table_scanner.sv
// ---------------------------------------------------------------------------
// bool3_truth_table_scanner
//
// Stimulus/capture stage for a 3-input combinational boolean block (inputs
// a, b, c; output e). After an accepted start it drives the eight input
// vectors {a,b,c} = 0..7 in ascending order. Each vector is held for
// SETTLE_CYCLES cycles, and then e is sampled for one cycle. The captured
// 8-bit truth table is compared with an expected table that is latched at
// start. The result reports whether any bit differs and the index of the
// first differing vector.
//
// Parameters
//   SETTLE_CYCLES  cycles each vector is held before e is sampled (1..255)
//
// Ports
//   clk_i       system clock, all logic on the rising edge
//   rst_i       synchronous, active-high reset
//   start_i     sweep request, honoured only in IDLE or DONE
//   expected_i  expected truth table; bit i = e for {a,b,c} = i
//   e_in_i      output e of the boolean block under test
//   a_o/b_o/c_o drive to the block under test (vector index bits 2/1/0)
//   busy_o      high while a sweep is in progress
//   done_o      high in DONE until the next accepted start or reset
//   table_o     captured truth table; bit i = e_in_i sampled for vector i
//   mismatch_o  captured table differs from the latched expected table
//   err_idx_o   index of the first mismatching vector; 0 when no mismatch
// ---------------------------------------------------------------------------
module bool3_truth_table_scanner #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] expected_i,
  input  logic       e_in_i,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] table_o,
  output logic       mismatch_o,
  output logic [2:0] err_idx_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Settle counter value on the last SETTLE cycle of each vector.
  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] exp_q, exp_d;
  logic [7:0] table_q, table_d;
  logic       mismatch_q, mismatch_d;
  logic [2:0] err_idx_q, err_idx_d;

  // NOTE: every _d signal gets its hold value first, so a path through the
  // case statement that does not assign it cannot infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    table_d    = table_q;
    mismatch_d = mismatch_q;
    err_idx_d  = err_idx_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          exp_d      = expected_i;
          idx_d      = 3'd0;
          cnt_d      = 8'd0;
          table_d    = 8'h00;
          mismatch_d = 1'b0;
          err_idx_d  = 3'd0;
          state_d    = SETTLE;
        end
      end

      SETTLE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        table_d[idx_q] = e_in_i;
        // Only the first mismatch sets err_idx; later ones leave it alone.
        if ((e_in_i != exp_q[idx_q]) && !mismatch_q) begin
          mismatch_d = 1'b1;
          err_idx_d  = idx_q;
        end
        if (idx_q == 3'd7) begin
          // idx stays at 7, so {a,b,c} holds 3'b111 in DONE.
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = 8'd0;
          state_d = SETTLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so that every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      cnt_q      <= 8'd0;
      exp_q      <= 8'h00;
      table_q    <= 8'h00;
      mismatch_q <= 1'b0;
      err_idx_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      table_q    <= table_d;
      mismatch_q <= mismatch_d;
      err_idx_q  <= err_idx_d;
    end
  end

  // The vector index drives the block under test directly. It is 0 after
  // reset, tracks idx during a sweep, and is 7 in DONE.
  assign {a_o, b_o, c_o} = idx_q;
  assign busy_o          = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done_o          = (state_q == DONE);
  assign table_o         = table_q;
  assign mismatch_o      = mismatch_q;
  assign err_idx_o       = err_idx_q;

endmodule

// File: tb/tb_bool3_truth_table_scanner.sv
// ---------------------------------------------------------------------------
// tb_bool3_truth_table_scanner
//
// Two scanners: one with SETTLE_CYCLES=4 and one with SETTLE_CYCLES=1. Each
// drives its own model of the reference block e = (a & b) | c. The truth
// table of that block over {a,b,c} = 0..7 is 8'hEA.
// ---------------------------------------------------------------------------
module tb_bool3_truth_table_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start0, start1;
  logic [7:0] expected;

  logic       a0, b0, c0, busy0, done0, mis0, e0;
  logic [7:0] tab0;
  logic [2:0] err0;
  logic       a1, b1, c1, busy1, done1, mis1, e1;
  logic [7:0] tab1;
  logic [2:0] err1;

  assign e0 = (a0 & b0) | c0;
  assign e1 = (a1 & b1) | c1;

  bool3_truth_table_scanner #(.SETTLE_CYCLES(4)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .expected_i(expected),
    .e_in_i(e0), .a_o(a0), .b_o(b0), .c_o(c0), .busy_o(busy0),
    .done_o(done0), .table_o(tab0), .mismatch_o(mis0), .err_idx_o(err0)
  );

  bool3_truth_table_scanner #(.SETTLE_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .expected_i(expected),
    .e_in_i(e1), .a_o(a1), .b_o(b1), .c_o(c1), .busy_o(busy1),
    .done_o(done1), .table_o(tab1), .mismatch_o(mis1), .err_idx_o(err1)
  );

  // Outputs of the scanner currently under observation.
  int         sel = 0;
  logic [2:0] o_abc, o_err;
  logic       o_busy, o_done, o_mis;
  logic [7:0] o_tab;

  always_comb begin
    if (sel == 0) begin
      o_abc = {a0, b0, c0}; o_busy = busy0; o_done = done0;
      o_tab = tab0; o_mis = mis0; o_err = err0;
    end else begin
      o_abc = {a1, b1, c1}; o_busy = busy1; o_done = done1;
      o_tab = tab1; o_mis = mis1; o_err = err1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    if (sel == 0) start0 = 1'b1;
    else          start1 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".abc"},      32'(o_abc),  32'd0);
    check({tag, ".busy"},     32'(o_busy), 32'd0);
    check({tag, ".done"},     32'(o_done), 32'd0);
    check({tag, ".table"},    32'(o_tab),  32'h00);
    check({tag, ".mismatch"}, 32'(o_mis),  32'd0);
    check({tag, ".err_idx"},  32'(o_err),  32'd0);
  endtask

  typedef struct {
    logic [7:0] exp_v;  // expected table given to the scanner
    logic [7:0] tab;    // table the reference block must produce
    logic       mis;
    logic [2:0] err;
  } vec_t;

  // Runs one sweep on the selected scanner. It checks latency, busy length,
  // the {a,b,c} stepping (vector k/period during the sweep, then 7), and the
  // final results.
  task automatic run_and_check(input vec_t v, input int settle,
                               input string tag);
    int per, total, n, busy_n, abc_bad;
    per   = settle + 1;
    total = 8 * per;
    expected = v.exp_v;
    pulse_start();                       // now just after accepting edge T0
    check({tag, ".busy_at_T0"}, 32'(o_busy), 32'd1);
    n       = 0;
    busy_n  = int'(o_busy);
    abc_bad = (o_abc != 3'd0) ? 1 : 0;
    while (!o_done && n < total + 20) begin
      tick();
      n++;
      if (!o_done) begin
        busy_n += int'(o_busy);
        if (int'(o_abc) != n / per) abc_bad++;
      end
    end
    check({tag, ".done_latency"}, 32'(n),       32'(total));
    check({tag, ".busy_cycles"},  32'(busy_n),  32'(total));
    check({tag, ".abc_steps"},    32'(abc_bad), 32'd0);
    check({tag, ".abc_done"},     32'(o_abc),   32'd7);
    check({tag, ".busy_done"},    32'(o_busy),  32'd0);
    check({tag, ".table"},        32'(o_tab),   32'(v.tab));
    check({tag, ".mismatch"},     32'(o_mis),   32'(v.mis));
    check({tag, ".err_idx"},      32'(o_err),   32'(v.err));
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    // {expected, table, mismatch, err_idx}; diff vs 8'hEA gives err_idx.
    vecs[0] = '{8'hEA, 8'hEA, 1'b0, 3'd0};  // exact match
    vecs[1] = '{8'hEB, 8'hEA, 1'b1, 3'd0};  // only bit 0 differs
    vecs[2] = '{8'h00, 8'hEA, 1'b1, 3'd1};  // first of several at bit 1
    vecs[3] = '{8'hEE, 8'hEA, 1'b1, 3'd2};  // only bit 2 differs
    vecs[4] = '{8'h6A, 8'hEA, 1'b1, 3'd7};  // only last vector differs
    vecs[5] = '{8'hFF, 8'hEA, 1'b1, 3'd0};  // bits 0,2,4 differ

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; expected = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state of both scanners.
    sel = 0; check_idle_outputs("reset0");
    sel = 1; check_idle_outputs("reset1");

    // Table-driven sweeps on the SETTLE_CYCLES=4 scanner (back-to-back
    // restarts from DONE).
    sel = 0;
    for (int i = 0; i < 6; i++) begin
      run_and_check(vecs[i], 4, $sformatf("vec%0d", i));
    end

    // DONE holds its results for several cycles.
    repeat (5) tick();
    check("hold.done",     32'(o_done), 32'd1);
    check("hold.table",    32'(o_tab),  32'hEA);
    check("hold.mismatch", 32'(o_mis),  32'd1);
    check("hold.abc",      32'(o_abc),  32'd7);

    // A start while busy and a change of expected mid-sweep are ignored.
    expected = 8'hEA;
    pulse_start();
    n = 0;
    while (!o_done && n < 60) begin
      tick();
      n++;
      if (n == 4)  expected = 8'hFF;   // sampled at T0+5
      if (n == 9)  start0 = 1'b1;      // sampled at T0+10
      if (n == 10) start0 = 1'b0;
    end
    check("ignore.done_latency", 32'(n),     32'd40);
    check("ignore.table",        32'(o_tab), 32'hEA);
    check("ignore.mismatch",     32'(o_mis), 32'd0);
    check("ignore.err_idx",      32'(o_err), 32'd0);

    // Reset mid-sweep at T0+17, then a fresh full sweep.
    expected = 8'h00;
    pulse_start();
    repeat (16) tick();
    check("midrst.busy_before", 32'(o_busy), 32'd1);
    rst = 1'b1;
    tick();                             // edge T0+17
    rst = 1'b0;
    check_idle_outputs("midrst");
    run_and_check(vecs[0], 4, "after_rst");

    // SETTLE_CYCLES=1 scanner: done at T0+16, vector changes every 2 cycles.
    sel = 1;
    run_and_check(vecs[0], 1, "s1_match");
    run_and_check(vecs[2], 1, "s1_zero");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
